// File: rtl/exwb_stage_if.sv
// ============================================================================
//  Module      : exwb_stage_if
//  Description : EX-to-WB pipeline bus: EX controls and data in, WB results out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface exwb_stage_if;
    logic        stall;
    logic        flush;
    logic        regwrite_EX;
    logic        enhilo_EX;
    logic [1:0]  regsel_EX;
    logic        rdrt_EX;
    logic        gpio_we_EX;
    logic [4:0]  rd_EX;
    logic [4:0]  rt_EX;
    logic [31:0] alu_lo_EX;
    logic [31:0] alu_hi_EX;
    logic [31:0] rt_data_EX;
    logic [31:0] gpio_in;
    logic        regwrite_WB;
    logic [4:0]  regdest_WB;
    logic [31:0] writedata_WB;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] gpio_out;

    modport master (
        output stall, flush, regwrite_EX, enhilo_EX, regsel_EX, rdrt_EX,
               gpio_we_EX, rd_EX, rt_EX, alu_lo_EX, alu_hi_EX, rt_data_EX,
               gpio_in,
        input  regwrite_WB, regdest_WB, writedata_WB, hi_q, lo_q, gpio_out
    );

    modport slave (
        input  stall, flush, regwrite_EX, enhilo_EX, regsel_EX, rdrt_EX,
               gpio_we_EX, rd_EX, rt_EX, alu_lo_EX, alu_hi_EX, rt_data_EX,
               gpio_in,
        output regwrite_WB, regdest_WB, writedata_WB, hi_q, lo_q, gpio_out
    );
endinterface

`default_nettype wire

// File: rtl/exwb_stage.sv
// ============================================================================
//  Module      : exwb_stage
//  Description : EX/WB pipeline register with HI/LO, GPIO out and synchronized
//                GPIO in. Optional GPIO path enabled by macro EXWB_GPIO_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exwb_stage (
    input  wire logic    clk,
    input  wire logic    rst,
    exwb_stage_if.slave  bus
);

    logic [4:0]  w_dest;
    logic [31:0] w_sel_data;

    logic        r_regwrite;
    logic [4:0]  r_regdest;
    logic [31:0] r_writedata;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

`ifdef EXWB_GPIO_EN
    logic [31:0] r_sync1;
    logic [31:0] r_sync2;
    logic [31:0] r_gpio_out;

    // Synchronizer free-runs through stall and flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 32'd0;
            r_sync2 <= 32'd0;
        end else begin
            r_sync1 <= bus.gpio_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gpio_out <= 32'd0;
        end else if (!bus.flush && !bus.stall && bus.gpio_we_EX) begin
            r_gpio_out <= bus.rt_data_EX;
        end
    end

    assign bus.gpio_out = r_gpio_out;
`else
    logic w_unused_gpio;
    assign w_unused_gpio = ^{bus.gpio_we_EX, bus.rt_data_EX, bus.gpio_in};
    assign bus.gpio_out  = 32'd0;
`endif

    assign w_dest = bus.rdrt_EX ? bus.rt_EX : bus.rd_EX;

    // HI/LO are read before this edge's update, so mfhi right after mult sees the new value.
    always_comb begin
        w_sel_data = bus.alu_lo_EX;
        case (bus.regsel_EX)
            2'b01:   w_sel_data = r_hi;
            2'b10:   w_sel_data = r_lo;
`ifdef EXWB_GPIO_EN
            2'b11:   w_sel_data = r_sync2;
`endif
            default: w_sel_data = bus.alu_lo_EX;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regwrite  <= 1'b0;
            r_regdest   <= 5'd0;
            r_writedata <= 32'd0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
        end else if (bus.flush) begin
            r_regwrite <= 1'b0;
        end else if (!bus.stall) begin
            r_regwrite  <= bus.regwrite_EX && (w_dest != 5'd0);
            r_regdest   <= w_dest;
            r_writedata <= w_sel_data;
            if (bus.enhilo_EX) begin
                r_hi <= bus.alu_hi_EX;
                r_lo <= bus.alu_lo_EX;
            end
        end
    end

    assign bus.regwrite_WB  = r_regwrite;
    assign bus.regdest_WB   = r_regdest;
    assign bus.writedata_WB = r_writedata;
    assign bus.hi_q         = r_hi;
    assign bus.lo_q         = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_exwb_stage.sv
// ============================================================================
//  Module      : tb_exwb_stage
//  Description : Directed bench for exwb_stage with a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exwb_stage;

`ifdef EXWB_GPIO_EN
    localparam bit c_GPIO = 1'b1;
`else
    localparam bit c_GPIO = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    exwb_stage_if bus ();

    exwb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural state after each edge.
    logic        m_rw;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    logic        m_valid;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_gpio;
    logic [31:0] m_hist [2];   // [0]=gpio_in at last edge, [1]=the edge before

    always @(posedge clk or posedge rst) begin
        logic [4:0]  dest;
        logic [31:0] data;
        logic [31:0] gpio_seen;
        if (rst) begin
            m_rw = 0; m_rd = 0; m_wd = 0; m_valid = 1;
            m_hi = 0; m_lo = 0; m_gpio = 0;
            m_hist[0] = 0; m_hist[1] = 0;
        end else begin
            gpio_seen = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = bus.gpio_in;
            if (bus.flush) begin
                m_rw = 0;
                m_valid = 0;
            end else if (!bus.stall) begin
                dest = bus.rdrt_EX ? bus.rt_EX : bus.rd_EX;
                if (bus.regsel_EX == 2'd1)      data = m_hi;
                else if (bus.regsel_EX == 2'd2) data = m_lo;
                else if (bus.regsel_EX == 2'd3 && c_GPIO) data = gpio_seen;
                else                            data = bus.alu_lo_EX;
                m_rw = bus.regwrite_EX && (dest != 0);
                m_rd = dest;
                m_wd = data;
                m_valid = 1;
                if (bus.enhilo_EX) begin
                    m_hi = bus.alu_hi_EX;
                    m_lo = bus.alu_lo_EX;
                end
                if (bus.gpio_we_EX && c_GPIO) m_gpio = bus.rt_data_EX;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("model.regwrite_WB", {31'd0, bus.regwrite_WB}, {31'd0, m_rw});
            chk("model.hi_q", bus.hi_q, m_hi);
            chk("model.lo_q", bus.lo_q, m_lo);
            chk("model.gpio_out", bus.gpio_out, m_gpio);
            if (m_valid) begin
                chk("model.regdest_WB", {27'd0, bus.regdest_WB}, {27'd0, m_rd});
                chk("model.writedata_WB", bus.writedata_WB, m_wd);
            end
        end
    end

    task automatic clr();
        bus.stall = 0; bus.flush = 0; bus.regwrite_EX = 0; bus.enhilo_EX = 0;
        bus.regsel_EX = 0; bus.rdrt_EX = 0; bus.gpio_we_EX = 0;
        bus.rd_EX = 0; bus.rt_EX = 0; bus.alu_lo_EX = 0; bus.alu_hi_EX = 0;
        bus.rt_data_EX = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1;
        clr();
        bus.gpio_in = 0;
        #12;
        chk("reset.regwrite_WB", {31'd0, bus.regwrite_WB}, 32'd0);
        chk("reset.writedata_WB", bus.writedata_WB, 32'd0);
        chk("reset.hi_q", bus.hi_q, 32'd0);
        chk("reset.gpio_out", bus.gpio_out, 32'd0);
        @(negedge clk);
        rst = 0;

        // add $5
        clr(); bus.regwrite_EX = 1; bus.rd_EX = 5; bus.alu_lo_EX = 32'h7;
        tick();
        chk("add.regwrite_WB", {31'd0, bus.regwrite_WB}, 32'd1);
        chk("add.regdest_WB", {27'd0, bus.regdest_WB}, 32'd5);
        chk("add.writedata_WB", bus.writedata_WB, 32'd7);

        // mult, mfhi, mflo back to back
        clr(); bus.enhilo_EX = 1; bus.alu_hi_EX = 32'h1; bus.alu_lo_EX = 32'hFFFF_FFFE; bus.rd_EX = 2;
        tick();
        chk("mult.regwrite_WB", {31'd0, bus.regwrite_WB}, 32'd0);
        chk("mult.hi_q", bus.hi_q, 32'h1);
        chk("mult.lo_q", bus.lo_q, 32'hFFFF_FFFE);
        clr(); bus.regwrite_EX = 1; bus.rd_EX = 3; bus.regsel_EX = 2'b01;
        tick();
        chk("mfhi.writedata_WB", bus.writedata_WB, 32'h1);
        chk("mfhi.regdest_WB", {27'd0, bus.regdest_WB}, 32'd3);
        clr(); bus.regwrite_EX = 1; bus.rd_EX = 4; bus.regsel_EX = 2'b10;
        tick();
        chk("mflo.writedata_WB", bus.writedata_WB, 32'hFFFF_FFFE);

        // addi to $0 via rt
        clr(); bus.regwrite_EX = 1; bus.rdrt_EX = 1; bus.rt_EX = 0; bus.rd_EX = 9; bus.alu_lo_EX = 32'h3;
        tick();
        chk("zero.regwrite_WB", {31'd0, bus.regwrite_WB}, 32'd0);

        // GPIO write under stall, then released
        clr(); bus.gpio_we_EX = 1; bus.rt_data_EX = 32'hA5A5_A5A5; bus.stall = 1;
        bus.regwrite_EX = 1; bus.rd_EX = 6; bus.alu_lo_EX = 32'h99;
        tick();
        chk("stall.gpio_out", bus.gpio_out, 32'd0);
        chk("stall.regwrite_WB", {31'd0, bus.regwrite_WB}, 32'd0);
        bus.stall = 0;
        tick();
        chk("unstall.gpio_out", bus.gpio_out, c_GPIO ? 32'hA5A5_A5A5 : 32'd0);
        chk("unstall.writedata_WB", bus.writedata_WB, 32'h99);

        // All three side effects in one instruction
        clr(); bus.enhilo_EX = 1; bus.gpio_we_EX = 1; bus.regwrite_EX = 1; bus.rd_EX = 7;
        bus.alu_lo_EX = 32'h11; bus.alu_hi_EX = 32'h22; bus.rt_data_EX = 32'h33;
        tick();
        chk("all3.hi_q", bus.hi_q, 32'h22);
        chk("all3.lo_q", bus.lo_q, 32'h11);
        chk("all3.writedata_WB", bus.writedata_WB, 32'h11);
        chk("all3.gpio_out", bus.gpio_out, c_GPIO ? 32'h33 : 32'd0);

        // Stall and flush together: flush wins, no HI/LO or GPIO update
        clr(); bus.stall = 1; bus.flush = 1; bus.regwrite_EX = 1; bus.rd_EX = 2;
        bus.enhilo_EX = 1; bus.alu_hi_EX = 32'h5; bus.gpio_we_EX = 1; bus.rt_data_EX = 32'h44;
        tick();
        chk("stallflush.regwrite_WB", {31'd0, bus.regwrite_WB}, 32'd0);
        chk("stallflush.hi_q", bus.hi_q, 32'h22);
        chk("stallflush.gpio_out", bus.gpio_out, c_GPIO ? 32'h33 : 32'd0);

        // GPIO input through the synchronizer, regsel 11 each cycle
        clr(); bus.regwrite_EX = 1; bus.rd_EX = 9; bus.regsel_EX = 2'b11; bus.alu_lo_EX = 32'h55;
        bus.gpio_in = 32'h1234;
        tick();
        chk("sync.N", bus.writedata_WB, c_GPIO ? 32'h0 : 32'h55);
        tick();
        chk("sync.N1", bus.writedata_WB, c_GPIO ? 32'h0 : 32'h55);
        tick();
        chk("sync.N2", bus.writedata_WB, c_GPIO ? 32'h1234 : 32'h55);

        // Asynchronous reset mid-stall/flush, then normal capture
        clr(); bus.enhilo_EX = 1; bus.alu_hi_EX = 32'hDEAD; bus.alu_lo_EX = 32'hBEEF;
        tick();
        chk("pre_rst.hi_q", bus.hi_q, 32'hDEAD);
        clr(); bus.stall = 1; bus.flush = 1; bus.regwrite_EX = 1; bus.rd_EX = 8;
        #1 rst = 1;
        #1;
        chk("async_rst.hi_q", bus.hi_q, 32'd0);
        chk("async_rst.lo_q", bus.lo_q, 32'd0);
        chk("async_rst.regwrite_WB", {31'd0, bus.regwrite_WB}, 32'd0);
        chk("async_rst.writedata_WB", bus.writedata_WB, 32'd0);
        chk("async_rst.gpio_out", bus.gpio_out, 32'd0);
        #1 rst = 0;
        clr(); bus.regwrite_EX = 1; bus.rd_EX = 10; bus.alu_lo_EX = 32'h77;
        tick();
        chk("post_rst.regwrite_WB", {31'd0, bus.regwrite_WB}, 32'd1);
        chk("post_rst.regdest_WB", {27'd0, bus.regdest_WB}, 32'd10);
        chk("post_rst.writedata_WB", bus.writedata_WB, 32'h77);

        clr();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
